// File: rtl/icache_nway.sv
// icache_nway: N-way set-associative instruction cache with true-LRU
// replacement, a LOOKUP/REFILL/RESP refill FSM, synchronous flush and
// saturating hit/miss counters. Sits between fetch and instruction memory.
module icache_nway #(
  parameter int WAYS   = 2,
  parameter int SETS   = 8,
  parameter int WORDS  = 8,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ins_req,
  input  logic [ADDR_W-1:0] instraddr,
  output logic [31:0]       instr,
  output logic              hit,
  output logic              abort,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  input  logic              mem_val,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int WSEL_W = $clog2(WORDS);
  localparam int OFF    = WSEL_W + 2;
  localparam int IDX    = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF - IDX;
  localparam int AGE_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int WAY_W  = AGE_W;

  typedef enum logic [1:0] {
    S_LOOKUP = 2'd0,
    S_REFILL = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  // One age per way; 0 is most recently used, WAYS-1 is the eviction candidate.
  typedef logic [WAYS-1:0][AGE_W-1:0] age_set_t;

  function automatic age_set_t age_reset();
    age_set_t r;
    for (int w = 0; w < WAYS; w++) r[w] = AGE_W'(w);
    return r;
  endfunction

  // Promote way w to MRU; only younger ways age, so the set stays a permutation.
  function automatic age_set_t lru_touch(input age_set_t a, input logic [WAY_W-1:0] w);
    age_set_t r;
    r = a;
    for (int j = 0; j < WAYS; j++)
      if (a[j] < a[w]) r[j] = a[j] + AGE_W'(1);
    r[w] = '0;
    return r;
  endfunction

  // Cache storage
  logic [WAYS-1:0]  valid_q [SETS];
  age_set_t         age_q   [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [31:0]      data_q  [SETS][WAYS][WORDS];

  // Control state
  state_e            state_q, state_d;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WAY_W-1:0]  victim_q;
  logic [WSEL_W-1:0] beat_q;
  logic              flush_pend_q;
  logic [31:0]       hit_cnt_q, miss_cnt_q;

  // Decoded request fields
  logic [IDX-1:0]    idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] wsel;
  logic [ADDR_W-1:0] line_addr;
  logic              unused_addr_lsbs;

  assign idx              = addr_q[OFF +: IDX];
  assign tag              = addr_q[ADDR_W-1 -: TAG_W];
  assign wsel             = addr_q[2 +: WSEL_W];
  assign line_addr        = {addr_q[ADDR_W-1:OFF], {OFF{1'b0}}};
  assign unused_addr_lsbs = ^addr_q[1:0];

  logic             hit_any;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim_sel;

  // Tag compare across the indexed set, and victim choice for a miss
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hit_any    = 1'b0;
    hit_way    = '0;
    victim_sel = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (age_q[idx][w] == AGE_W'(WAYS-1)) victim_sel = WAY_W'(w);
    end
    // Any invalid way beats the LRU way; descending scan leaves the lowest index.
    for (int w = WAYS-1; w >= 0; w--)
      if (!valid_q[idx][w]) victim_sel = WAY_W'(w);
  end

  logic lookup_hit, lookup_miss, last_beat, clear_all, accept;

  // A flush in the lookup cycle forces a miss since the lines are about to vanish.
  assign lookup_hit  = (state_q == S_LOOKUP) && req_q && hit_any && !flush;
  assign lookup_miss = (state_q == S_LOOKUP) && req_q && !lookup_hit;
  assign last_beat   = (state_q == S_REFILL) && mem_val && (beat_q == WSEL_W'(WORDS-1));
  // Flush outside REFILL acts at once; inside REFILL it waits for the final beat.
  assign clear_all   = (flush && state_q != S_REFILL) ||
                       (last_beat && (flush_pend_q || flush));
  assign accept      = (state_q == S_LOOKUP && !lookup_miss) || (state_q == S_RESP);

  // Next-state and fetch/memory-side outputs
  always_comb begin
    state_d  = state_q;
    instr    = '0;
    hit      = 1'b0;
    abort    = 1'b0;
    mem_req  = 1'b0;
    mem_addr = '0;
    unique case (state_q)
      S_LOOKUP: begin
        if (lookup_hit) begin
          hit   = 1'b1;
          instr = data_q[idx][hit_way][wsel];
        end
        if (lookup_miss) begin
          abort   = 1'b1;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = line_addr;
        abort    = 1'b1;
        if (last_beat) state_d = S_RESP;
      end
      S_RESP: begin
        // Replay cycle: serve the requested word from the line just filled.
        hit     = 1'b1;
        instr   = data_q[idx][victim_q][wsel];
        state_d = S_LOOKUP;
      end
      default: state_d = S_LOOKUP;
    endcase
  end

  // FSM register, request capture, refill bookkeeping and counters
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q      <= S_LOOKUP;
      req_q        <= 1'b0;
      addr_q       <= '0;
      victim_q     <= '0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q  <= ins_req;
        addr_q <= instraddr;
      end
      if (lookup_miss) begin
        victim_q <= flush ? '0 : victim_sel;
        beat_q   <= '0;
      end
      if (state_q == S_REFILL && mem_val) beat_q <= beat_q + WSEL_W'(1);
      if (last_beat)
        flush_pend_q <= 1'b0;
      else if (state_q == S_REFILL && flush)
        flush_pend_q <= 1'b1;
      if (lookup_hit && hit_cnt_q != 32'hFFFF_FFFF)   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (lookup_miss && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  // Valid bits and LRU ages: cleared by reset/flush, updated on fill and hit
  always_ff @(posedge clk) begin
    if (reset || clear_all) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        age_q[s]   <= age_reset();
      end
    end else if (last_beat) begin
      valid_q[idx][victim_q] <= 1'b1;
      age_q[idx]             <= lru_touch(age_q[idx], victim_q);
    end else if (lookup_hit) begin
      age_q[idx] <= lru_touch(age_q[idx], hit_way);
    end
  end

  // Line data and tags, written beat by beat into the victim way
  always_ff @(posedge clk) begin
    // NOTE: data and tag arrays are not reset; valid bits alone decide whether they are used.
    if (!reset && state_q == S_REFILL && mem_val)
      data_q[idx][victim_q][beat_q] <= mem_data;
    if (!reset && last_beat)
      tag_q[idx][victim_q] <= tag;
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_icache_nway.sv
// tb_icache_nway: directed, table-driven bench for icache_nway. A default
// 2-way/8-set/8-word instance and a 4-way/16-set/4-word instance share one
// set of bench signals; sel picks which one is driven and observed.
module tb_icache_nway;

  logic        clk;
  logic        reset;
  logic        sel;
  logic        ins_req;
  logic [31:0] instraddr;
  logic        flush;
  logic [31:0] mem_data;
  logic        mem_val;

  logic [31:0] instr, mem_addr, hit_cnt, miss_cnt;
  logic        hit, abort, mem_req;

  logic [31:0] instr_a, mem_addr_a, hit_cnt_a, miss_cnt_a;
  logic        hit_a, abort_a, mem_req_a;
  logic [31:0] instr_b, mem_addr_b, hit_cnt_b, miss_cnt_b;
  logic        hit_b, abort_b, mem_req_b;

  icache_nway dut_a (
    .clk(clk), .reset(reset),
    .ins_req(ins_req && !sel), .instraddr(instraddr),
    .instr(instr_a), .hit(hit_a), .abort(abort_a),
    .flush(flush && !sel),
    .mem_req(mem_req_a), .mem_addr(mem_addr_a),
    .mem_data(mem_data), .mem_val(mem_val && !sel),
    .hit_cnt(hit_cnt_a), .miss_cnt(miss_cnt_a)
  );

  icache_nway #(.WAYS(4), .SETS(16), .WORDS(4), .ADDR_W(32)) dut_b (
    .clk(clk), .reset(reset),
    .ins_req(ins_req && sel), .instraddr(instraddr),
    .instr(instr_b), .hit(hit_b), .abort(abort_b),
    .flush(flush && sel),
    .mem_req(mem_req_b), .mem_addr(mem_addr_b),
    .mem_data(mem_data), .mem_val(mem_val && sel),
    .hit_cnt(hit_cnt_b), .miss_cnt(miss_cnt_b)
  );

  assign instr    = sel ? instr_b    : instr_a;
  assign hit      = sel ? hit_b      : hit_a;
  assign abort    = sel ? abort_b    : abort_a;
  assign mem_req  = sel ? mem_req_b  : mem_req_a;
  assign mem_addr = sel ? mem_addr_b : mem_addr_a;
  assign hit_cnt  = sel ? hit_cnt_b  : hit_cnt_a;
  assign miss_cnt = sel ? miss_cnt_b : miss_cnt_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_hits   = 0;
  int exp_misses = 0;

  typedef struct {
    logic [31:0] addr;
    bit          exp_hit;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vec_a [8];
  vec_t vec_b [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Instruction memory contents: word at byte address a.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) ^ 32'h0000_00E0;
  endfunction

  task automatic check_reset_outputs(input string name);
    check({name, " hit"},      {31'd0, hit},     32'd0);
    check({name, " abort"},    {31'd0, abort},   32'd0);
    check({name, " instr"},    instr,            32'd0);
    check({name, " mem_req"},  {31'd0, mem_req}, 32'd0);
    check({name, " mem_addr"}, mem_addr,         32'd0);
    check({name, " hit_cnt"},  hit_cnt,          32'd0);
    check({name, " miss_cnt"}, miss_cnt,         32'd0);
  endtask

  // Present one fetch, serve the refill on a miss, and check the result cycle.
  // flush_beat pulses flush alongside that beat; reset_beat resets instead of that beat.
  task automatic fetch(input logic [31:0] addr, input bit exp_hit, input logic [31:0] exp_instr,
                       input int flush_beat, input int reset_beat, input string name);
    int          nw;
    logic [31:0] line;
    nw   = sel ? 4 : 8;
    line = addr & (sel ? 32'hFFFF_FFF0 : 32'hFFFF_FFE0);
    ins_req   = 1'b1;
    instraddr = addr;
    tick();
    if (exp_hit) begin
      check({name, " hit"},      {31'd0, hit},   32'd1);
      check({name, " instr"},    instr,          exp_instr);
      check({name, " abort"},    {31'd0, abort}, 32'd0);
      check({name, " hit_cnt"},  hit_cnt,        32'(exp_hits));
      check({name, " miss_cnt"}, miss_cnt,       32'(exp_misses));
      exp_hits++;
      return;
    end
    check({name, " miss hit"},   {31'd0, hit},   32'd0);
    check({name, " miss abort"}, {31'd0, abort}, 32'd1);
    exp_misses++;
    tick();
    for (int i = 0; i < nw; i++) begin
      check({name, " mem_req"},  {31'd0, mem_req}, 32'd1);
      check({name, " mem_addr"}, mem_addr,         line);
      check({name, " refill abort"}, {31'd0, abort}, 32'd1);
      if (i == reset_beat) begin
        reset   = 1'b1;
        mem_val = 1'b0;
        ins_req = 1'b0;
        tick();
        reset = 1'b0;
        check_reset_outputs({name, " after reset"});
        exp_hits   = 0;
        exp_misses = 0;
        return;
      end
      mem_val  = 1'b1;
      mem_data = mem_word(line + 32'(4 * i));
      flush    = (i == flush_beat);
      tick();
    end
    mem_val = 1'b0;
    flush   = 1'b0;
    check({name, " resp hit"},     {31'd0, hit},     32'd1);
    check({name, " resp instr"},   instr,            exp_instr);
    check({name, " resp abort"},   {31'd0, abort},   32'd0);
    check({name, " resp mem_req"}, {31'd0, mem_req}, 32'd0);
    check({name, " resp hit_cnt"}, hit_cnt,          32'(exp_hits));
    check({name, " resp miss_cnt"}, miss_cnt,        32'(exp_misses));
  endtask

  initial begin
    // 2-way, 8 sets, 8 words: set 0 holds lines 0x100 (A), 0x200 (B), 0x300 (C).
    vec_a[0] = '{32'h0000_0104, 1'b0, 32'h0000_00A1};  // cold miss
    vec_a[1] = '{32'h0000_0100, 1'b1, 32'h0000_00A0};  // back-to-back hits
    vec_a[2] = '{32'h0000_011C, 1'b1, 32'h0000_00A7};
    vec_a[3] = '{32'h0000_0208, 1'b0, 32'h0000_0062};  // B fills the other way
    vec_a[4] = '{32'h0000_0100, 1'b1, 32'h0000_00A0};  // touch A, B becomes LRU
    vec_a[5] = '{32'h0000_0300, 1'b0, 32'h0000_0020};  // C evicts B
    vec_a[6] = '{32'h0000_0104, 1'b1, 32'h0000_00A1};  // A survived
    vec_a[7] = '{32'h0000_0204, 1'b0, 32'h0000_0061};  // B was evicted

    // 4-way, 16 sets, 4 words: five tags into set 0, then the oldest again.
    vec_b[0] = '{32'h0000_0004, 1'b0, 32'h0000_00E1};
    vec_b[1] = '{32'h0000_0108, 1'b0, 32'h0000_00A2};
    vec_b[2] = '{32'h0000_020C, 1'b0, 32'h0000_0063};
    vec_b[3] = '{32'h0000_0300, 1'b0, 32'h0000_0020};
    vec_b[4] = '{32'h0000_0404, 1'b0, 32'h0000_01E1};  // evicts tag 0
    vec_b[5] = '{32'h0000_0000, 1'b0, 32'h0000_00E0};  // oldest misses, evicts tag 1
    vec_b[6] = '{32'h0000_0200, 1'b1, 32'h0000_0060};
    vec_b[7] = '{32'h0000_030C, 1'b1, 32'h0000_0023};
    vec_b[8] = '{32'h0000_0408, 1'b1, 32'h0000_01E2};

    sel       = 1'b0;
    reset     = 1'b1;
    ins_req   = 1'b0;
    instraddr = '0;
    flush     = 1'b0;
    mem_data  = '0;
    mem_val   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_reset_outputs("reset");

    // Stray memory beat while idle must be ignored.
    mem_val  = 1'b1;
    mem_data = 32'hDEAD_BEEF;
    tick();
    mem_val = 1'b0;
    check("idle mem_val hit_cnt",  hit_cnt,  32'd0);
    check("idle mem_val miss_cnt", miss_cnt, 32'd0);

    for (int i = 0; i < 8; i++)
      fetch(vec_a[i].addr, vec_a[i].exp_hit, vec_a[i].exp_instr, -1, -1, $sformatf("a%0d", i));
    check("table a hit_cnt",  hit_cnt,  32'd4);
    check("table a miss_cnt", miss_cnt, 32'd4);

    // Flush while idle: a line that hit just before must miss.
    fetch(32'h0000_0100, 1'b1, 32'h0000_00A0, -1, -1, "pre-flush");
    ins_req = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    // Flush during beat 3: word still delivered, line not retained.
    fetch(32'h0000_0100, 1'b0, 32'h0000_00A0, 3, -1, "flush refill");
    fetch(32'h0000_0104, 1'b0, 32'h0000_00A1, -1, -1, "post-flush rereq");
    fetch(32'h0000_0108, 1'b1, 32'h0000_00A2, -1, -1, "post-flush hit");

    // Reset after beat 4 of a burst, then refill the same line cleanly.
    ins_req = 1'b0;
    tick();
    fetch(32'h0000_040C, 1'b0, 32'h0000_01E3, -1, 5, "reset refill");
    tick();
    fetch(32'h0000_040C, 1'b0, 32'h0000_01E3, -1, -1, "after reset miss");
    fetch(32'h0000_0404, 1'b1, 32'h0000_01E1, -1, -1, "after reset hit");

    // Parameter sweep on the 4-way instance.
    ins_req = 1'b0;
    tick();
    sel        = 1'b1;
    exp_hits   = 0;
    exp_misses = 0;
    for (int i = 0; i < 9; i++)
      fetch(vec_b[i].addr, vec_b[i].exp_hit, vec_b[i].exp_instr, -1, -1, $sformatf("b%0d", i));
    ins_req = 1'b0;
    tick();
    check("sweep hit_cnt",  hit_cnt,  32'd3);
    check("sweep miss_cnt", miss_cnt, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_nway.md
Name: icache_nway

Overview:
- Parametrised N-way set-associative instruction cache for the MIPS core, placed between the fetch stage and the instruction memory port.
- Generalises the fixed 2-way/8-set/8-word icache:
  - configurable ways, sets and line size
  - true-LRU replacement with correct intra-set ordering
  - explicit refill FSM with a replay/response cycle
  - synchronous flush (invalidate-all) for self-modifying code
  - saturating hit/miss performance counters

Parameters:
- WAYS, 2, associativity; power of two, ≥1.
- SETS, 8, sets per way; power of two, ≥2.
- WORDS, 8, 32-bit words per line; power of two, ≥2.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ins_req  in  1  fetch request; sampled on clk.
- instraddr  in  ADDR_W  byte address of the fetch; word-aligned.
- instr  out  32  fetched instruction; valid when hit=1.
- hit  out  1  instr valid this cycle.
- abort  out  1  stall fetch; the CPU holds ins_req and instraddr while abort=1.
- flush  in  1  invalidate all lines.
- mem_req  out  1  refill request, held high for the whole burst.
- mem_addr  out  ADDR_W  line-aligned refill address.
- mem_data  in  32  refill beat data.
- mem_val  in  1  refill beat valid.
- hit_cnt  out  32  saturating count of hits.
- miss_cnt  out  32  saturating count of misses.

Behaviour:
- Address split:
  - OFF = clog2(WORDS)+2
  - IDX = clog2(SETS)
  - tag = ADDR_W-OFF-IDX bits
  - word select = addr[OFF-1:2]
- Storage per way per set: valid bit, tag, WORDS×32 data. Per set: WAYS age fields of max(1, clog2(WAYS)) bits.
- FSM states: LOOKUP, REFILL, RESP.
- LOOKUP:
  - ins_req=1 at edge T registers req_q, addr_q and the indexed set.
  - At T+1, hit = req_q & any way (valid & tag match); instr = word of the matching way; abort = req_q & ~hit.
  - Miss at T+1: go to REFILL at T+2; victim way latched at T+1.
  - A new request is accepted in the same cycle as a hit (back-to-back hits, 1 per cycle).
- REFILL:
  - mem_req=1, mem_addr = {addr_q line bits, OFF'b0}, stable for the whole state.
  - Beat counter counts mem_val; beat i is word i.
  - On the edge capturing beat WORDS-1: the line is written to the victim way (valid=1, tag), LRU is updated, and the state goes to RESP.
  - mem_req drops in RESP; abort=1 throughout; ins_req is ignored.
- RESP: hit=1, abort=0, instr = requested word of the just-filled line; return to LOOKUP. A request presented in RESP is accepted as in LOOKUP.
- Victim selection: lowest-index invalid way; else the way with age == WAYS-1.
- LRU update on hit or fill to way w:
  - ways with age < age[w] increment
  - age[w] becomes 0
  - ages in a set stay a permutation of 0..WAYS-1
- Reset and flush both set age[w] = w in every set.
- Flush:
  - In LOOKUP/RESP: all valid bits cleared and ages reinitialised at the next edge; a lookup in the same cycle reports a miss.
  - In REFILL: flush_pend is set. The burst completes, but the line is written with valid=0. RESP still delivers the word. Valid bits and ages are cleared at that edge.
- Counters:
  - hit_cnt increments on each LOOKUP hit cycle; RESP does not count.
  - miss_cnt increments on each miss detection.
  - Both saturate at 0xFFFFFFFF.
  - Flush does not clear counters.
- mem_val outside REFILL is ignored.
- Reset values:
  - instr=0, hit=0, abort=0, mem_req=0, mem_addr=0
  - hit_cnt=0, miss_cnt=0
  - state=LOOKUP, all valid=0, beat counter=0, flush_pend=0
- Reset mid-REFILL: the burst is abandoned and mem_req=0 from the next cycle.

Test Plan:
- Cold miss, WAYS=2 SETS=8 WORDS=8:
  - Stimulus: req 0x0000_0104; memory returns 8 beats 0xA0..0xA7, one per cycle.
  - Required: abort for 1 lookup cycle + REFILL; mem_addr=0x0000_0100 stable; RESP instr=0xA1, hit=1; miss_cnt=1.
- Back-to-back hits:
  - Stimulus: after the fill, req 0x100, 0x11C on consecutive cycles.
  - Required: hit=1 each cycle, instr=0xA0 then 0xA7, abort=0; hit_cnt=2.
- LRU eviction:
  - Stimulus: fill tags A, B into set 0; hit A; miss on tag C in set 0.
  - Required: B's way is replaced; a following req to A hits; a req to B misses.
- Flush:
  - Stimulus: flush while idle.
  - Required: previously-hitting 0x100 misses next access.
  - Stimulus: flush during REFILL beat 3.
  - Required: RESP still returns the correct word; an immediate re-request misses.
- Reset mid-refill:
  - Stimulus: assert reset after beat 4.
  - Required: mem_req=0 next cycle, all outputs at reset values; a new req to the same line misses and refills correctly.
- Parameter sweep:
  - Stimulus: WAYS=4 SETS=16 WORDS=4; 5 distinct tags to one set, then re-access the oldest.
  - Required: oldest was evicted, miss; the other three hit; counters are consistent.
